// File: rtl/dds_cfg_loader_pkg.sv
// Shared types and constants for the DDS configuration loader.
package dds_pkg;

   // Ring select codes driven onto the DDS address bus.
   localparam logic [1:0] THETAS = 2'd0;
   localparam logic [1:0] DELTAS = 2'd1;
   localparam logic [1:0] AMPLS  = 2'd2;

   typedef enum logic [1:0] {
      CLEAR,
      BURST,
      RUN
   } dds_ld_state_t;

   // Maps a flat set index (theta block, then delta block, then amplitude block)
   // to the ring it belongs to; avoids a generic divider.
   function automatic logic [1:0] ring_sel(input int idx, input int n_ch);
      if (idx < n_ch) begin
         return THETAS;
      end else if (idx < 2 * n_ch) begin
         return DELTAS;
      end else begin
         return AMPLS;
      end
   endfunction

endpackage

// File: rtl/dds_cfg_loader_if.sv
// Valid/ready word stream carrying configuration sets into the loader.
interface dds_cfg_loader_if #(
   parameter int SIG_WIDTH = 16
);
   logic [SIG_WIDTH-1:0] data;
   logic                 valid;
   logic                 last;
   logic                 ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/dds_cfg_buf.sv
// Set buffer: one register per word, synchronous write, combinational read
// so the burst can look one index ahead into the output registers.
module dds_cfg_buf #(
   parameter int SIG_WIDTH = 16,
   parameter int DEPTH     = 12,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [SIG_WIDTH-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic [SIG_WIDTH-1:0] rdata
);

   logic [SIG_WIDTH-1:0] mem [DEPTH];

   // Store each accepted stream word at its set position.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dds_cfg_loader.sv
// Collects a complete theta/delta/amplitude set, then bursts it gap-free into
// the DDS rings and leaves the DDS running until the next set or a stop.
module dds_cfg_loader
   import dds_pkg::*;
#(
   parameter int SIG_WIDTH = 16,
   parameter int N_CH      = 4
) (
   input  logic                 clk,
   input  logic                 a_rst_n,
   dds_cfg_loader_if.slave      s,
   input  logic                 i_stop,
   input  logic                 i_clr_err,
   output logic                 o_dds_rst,
   output logic                 o_dds_start,
   output logic [1:0]           o_dds_addrs,
   output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
   output logic                 o_busy,
   output logic                 o_err
);

   localparam int              N_WORDS  = 3 * N_CH;
   localparam int              CW       = $clog2(N_WORDS);
   localparam logic [CW-1:0]   LAST_IDX = CW'(N_WORDS - 1);

   dds_ld_state_t        state_reg, state_next;
   logic [CW-1:0]        wcnt_reg, wcnt_next;
   logic [CW-1:0]        rcnt_reg, rcnt_next;
   logic                 err_reg, err_next;
   logic                 dds_rst_reg, dds_rst_next;
   logic                 dds_start_reg, dds_start_next;
   logic [1:0]           dds_addrs_reg, dds_addrs_next;
   logic [SIG_WIDTH-1:0] dds_data_reg, dds_data_next;

   logic                 accept;
   logic                 at_last;
   logic                 set_done;
   logic                 frame_err;
   logic                 buf_we;
   logic [SIG_WIDTH-1:0] rd_data;

   assign s.ready   = (state_reg != BURST);
   assign accept    = s.valid & s.ready;
   assign at_last   = (wcnt_reg == LAST_IDX);
   assign set_done  = accept & s.last & at_last;
   assign frame_err = accept & (s.last ^ at_last);

   // Read address follows the next burst index so the data register loads
   // the word that belongs to the upcoming cycle.
   dds_cfg_buf #(
      .SIG_WIDTH (SIG_WIDTH),
      .DEPTH     (N_WORDS),
      .AW        (CW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (wcnt_reg),
      .wdata (s.data),
      .raddr (rcnt_next),
      .rdata (rd_data)
   );

   // Next-state, counter, framing and DDS output logic.
   always_comb begin
      state_next     = state_reg;
      wcnt_next      = wcnt_reg;
      rcnt_next      = rcnt_reg;
      err_next       = err_reg & ~i_clr_err;
      buf_we         = 1'b0;
      dds_rst_next   = 1'b0;
      dds_start_next = 1'b0;
      dds_addrs_next = THETAS;
      dds_data_next  = '0;

      if (i_stop) begin
         // Abort wins over everything: whatever was collected is dropped.
         state_next = CLEAR;
         wcnt_next  = '0;
         rcnt_next  = '0;
      end else begin
         if (accept) begin
            buf_we = 1'b1;
            if (set_done) begin
               state_next = BURST;
               rcnt_next  = '0;
            end else if (frame_err) begin
               err_next  = 1'b1;
               wcnt_next = '0;
            end else begin
               wcnt_next = wcnt_reg + 1'b1;
            end
         end

         // No words are accepted in BURST, so this never overlaps the above.
         if (state_reg == BURST) begin
            if (rcnt_reg == LAST_IDX) begin
               state_next = RUN;
               rcnt_next  = '0;
               wcnt_next  = '0;
            end else begin
               rcnt_next = rcnt_reg + 1'b1;
            end
         end
      end

      case (state_next)
         CLEAR: dds_rst_next = 1'b1;
         BURST: begin
            dds_addrs_next = ring_sel(int'(rcnt_next), N_CH);
            dds_data_next  = rd_data;
         end
         RUN:     dds_start_next = 1'b1;
         default: dds_rst_next   = 1'b1;
      endcase
   end

   // State, counters, sticky error and registered DDS outputs.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_reg     <= CLEAR;
         wcnt_reg      <= '0;
         rcnt_reg      <= '0;
         err_reg       <= 1'b0;
         dds_rst_reg   <= 1'b1;
         dds_start_reg <= 1'b0;
         dds_addrs_reg <= THETAS;
         dds_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         wcnt_reg      <= wcnt_next;
         rcnt_reg      <= rcnt_next;
         err_reg       <= err_next;
         dds_rst_reg   <= dds_rst_next;
         dds_start_reg <= dds_start_next;
         dds_addrs_reg <= dds_addrs_next;
         dds_data_reg  <= dds_data_next;
      end
   end

   assign o_dds_rst       = dds_rst_reg;
   assign o_dds_start     = dds_start_reg;
   assign o_dds_addrs     = dds_addrs_reg;
   assign o_dds_fifo_data = dds_data_reg;
   assign o_busy          = (state_reg == BURST);
   assign o_err           = err_reg;

endmodule

// File: tb/tb_dds_cfg_loader.sv
// Directed bench for the DDS configuration loader (N_CH=4, SIG_WIDTH=16).
module tb_dds_cfg_loader;

   logic        clk;
   logic        a_rst_n;
   logic        i_stop;
   logic        i_clr_err;
   logic        o_dds_rst;
   logic        o_dds_start;
   logic [1:0]  o_dds_addrs;
   logic [15:0] o_dds_fifo_data;
   logic        o_busy;
   logic        o_err;

   int n_vec = 0;
   int n_bad = 0;

   dds_cfg_loader_if #(.SIG_WIDTH(16)) sif ();

   dds_cfg_loader #(
      .SIG_WIDTH (16),
      .N_CH      (4)
   ) dut (
      .clk             (clk),
      .a_rst_n         (a_rst_n),
      .s               (sif),
      .i_stop          (i_stop),
      .i_clr_err       (i_clr_err),
      .o_dds_rst       (o_dds_rst),
      .o_dds_start     (o_dds_start),
      .o_dds_addrs     (o_dds_addrs),
      .o_dds_fifo_data (o_dds_fifo_data),
      .o_busy          (o_busy),
      .o_err           (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends n_words starting at base; s_last on index last_at (-1 = never).
   task automatic send_set(input logic [15:0] base, input int n_words, input int last_at, input bit gaps);
      for (int i = 0; i < n_words; i++) begin
         int idle = 0;
         while (gaps && ($urandom_range(0, 1) == 1) && (idle < 8)) begin
            step();
            idle++;
         end
         sif.valid = 1'b1;
         sif.data  = base + 16'(i);
         sif.last  = (i == last_at);
         step();
         sif.valid = 1'b0;
         sif.last  = 1'b0;
      end
      $display("tx words base=0x%04h count=%0d last_at=%0d gaps=%0d", base, n_words, last_at, gaps);
   endtask

   // Expects 12 consecutive burst cycles carrying base..base+11, then RUN.
   task automatic burst_check(input logic [15:0] base);
      for (int k = 0; k < 12; k++) begin
         check_value("burst_busy", 32'(o_busy), 32'd1);
         check_value("burst_ready", 32'(sif.ready), 32'd0);
         check_value("burst_rst", 32'(o_dds_rst), 32'd0);
         check_value("burst_start", 32'(o_dds_start), 32'd0);
         check_value("burst_addrs", 32'(o_dds_addrs), 32'(k / 4));
         check_value("burst_data", 32'(o_dds_fifo_data), 32'(base + 16'(k)));
         step();
      end
      check_value("run_start", 32'(o_dds_start), 32'd1);
      check_value("run_busy", 32'(o_busy), 32'd0);
      check_value("run_rst", 32'(o_dds_rst), 32'd0);
      check_value("run_ready", 32'(sif.ready), 32'd1);
      check_value("run_data", 32'(o_dds_fifo_data), 32'd0);
      $display("tx burst base=0x%04h checked", base);
   endtask

   initial begin
      a_rst_n   = 1'b0;
      i_stop    = 1'b0;
      i_clr_err = 1'b0;
      sif.valid = 1'b0;
      sif.last  = 1'b0;
      sif.data  = '0;
      step();
      step();

      // 1: reset values
      check_value("rst_dds_rst", 32'(o_dds_rst), 32'd1);
      check_value("rst_ready", 32'(sif.ready), 32'd1);
      check_value("rst_start", 32'(o_dds_start), 32'd0);
      check_value("rst_err", 32'(o_err), 32'd0);
      check_value("rst_busy", 32'(o_busy), 32'd0);
      a_rst_n = 1'b1;
      step();
      check_value("clear_rst", 32'(o_dds_rst), 32'd1);

      // 2: basic load
      send_set(16'h0001, 12, 11, 1'b0);
      burst_check(16'h0001);
      step();
      check_value("run_hold", 32'(o_dds_start), 32'd1);

      // 3: early s_last in RUN, then clear error and reload
      send_set(16'h00A1, 5, 4, 1'b0);
      check_value("err_set", 32'(o_err), 32'd1);
      check_value("err_busy", 32'(o_busy), 32'd0);
      check_value("err_start", 32'(o_dds_start), 32'd1);
      step();
      step();
      check_value("err_noburst", 32'(o_busy), 32'd0);
      check_value("err_sticky", 32'(o_err), 32'd1);
      i_clr_err = 1'b1;
      step();
      i_clr_err = 1'b0;
      check_value("err_clr", 32'(o_err), 32'd0);
      send_set(16'h0101, 12, 11, 1'b0);
      burst_check(16'h0101);

      // 4: stop on burst cycle 6, then reload
      send_set(16'h0201, 12, 11, 1'b0);
      for (int k = 0; k < 6; k++) begin
         check_value("stop_pre_data", 32'(o_dds_fifo_data), 32'(16'h0201 + 16'(k)));
         step();
      end
      check_value("stop_cyc6_data", 32'(o_dds_fifo_data), 32'h0207);
      i_stop = 1'b1;
      step();
      i_stop = 1'b0;
      check_value("stop_rst", 32'(o_dds_rst), 32'd1);
      check_value("stop_start", 32'(o_dds_start), 32'd0);
      check_value("stop_busy", 32'(o_busy), 32'd0);
      check_value("stop_data", 32'(o_dds_fifo_data), 32'd0);
      check_value("stop_ready", 32'(sif.ready), 32'd1);
      send_set(16'h0001, 12, 11, 1'b0);
      burst_check(16'h0001);

      // 5: random valid gaps during collection
      send_set(16'h0001, 12, 11, 1'b1);
      burst_check(16'h0001);

      // 6: reset mid-collection, then a full 12 new words are needed
      send_set(16'h0301, 7, -1, 1'b0);
      check_value("prerst_start", 32'(o_dds_start), 32'd1);
      a_rst_n = 1'b0;
      #1;
      check_value("arst_dds_rst", 32'(o_dds_rst), 32'd1);
      check_value("arst_start", 32'(o_dds_start), 32'd0);
      check_value("arst_busy", 32'(o_busy), 32'd0);
      check_value("arst_err", 32'(o_err), 32'd0);
      check_value("arst_ready", 32'(sif.ready), 32'd1);
      step();
      a_rst_n = 1'b1;
      step();
      send_set(16'h0401, 11, -1, 1'b0);
      check_value("post_rst_busy", 32'(o_busy), 32'd0);
      check_value("post_rst_err", 32'(o_err), 32'd0);
      check_value("post_rst_clear", 32'(o_dds_rst), 32'd1);
      send_set(16'h040C, 1, 0, 1'b0);
      burst_check(16'h0401);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
